// File: rtl/mac_package.sv
// Shared MAC accelerator types: engine control/flag structs, engine state enum and size constants.
package mac_package;

  localparam int unsigned MAC_CNT_LEN = 1024;
  localparam int unsigned MAC_CNT_W   = $clog2(MAC_CNT_LEN) + 1;
  localparam int unsigned MAC_SHIFT_W = 6;

  typedef struct packed {
    logic                   clear;
    logic                   enable;
    logic                   simple_mul;
    logic                   start;
    logic [MAC_SHIFT_W-1:0] shift;
    logic [MAC_CNT_W-1:0]   len;
  } ctrl_engine_t;

  typedef struct packed {
    logic [MAC_CNT_W-1:0] cnt;
  } flags_engine_t;

  typedef enum logic [0:0] {
    ENG_IDLE,
    ENG_RUN
  } state_engine_t;

endpackage

// File: rtl/mac_engine_if.sv
// Operand/result stream bundle of the MAC engine: a, b, c in and d out, each valid/ready.
interface mac_engine_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  a_valid;
  logic                  a_ready;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  c_valid;
  logic                  c_ready;
  logic [DATA_WIDTH-1:0] c_data;
  logic                  d_valid;
  logic                  d_ready;
  logic [DATA_WIDTH-1:0] d_data;

  // Engine side.
  modport slave (
    input  a_valid, a_data, b_valid, b_data, c_valid, c_data, d_ready,
    output a_ready, b_ready, c_ready, d_valid, d_data
  );

  // Streamer side.
  modport master (
    output a_valid, a_data, b_valid, b_data, c_valid, c_data, d_ready,
    input  a_ready, b_ready, c_ready, d_valid, d_data
  );
endinterface

// File: rtl/mac_engine_mul_stage.sv
// Stage 1 of the MAC engine: registers the full-width signed product plus c and first/last tags.
module mac_engine_mul_stage #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  input  logic [DATA_WIDTH-1:0]   c_i,
  input  logic                    first_i,
  input  logic                    last_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [2*DATA_WIDTH-1:0] prod_o,
  output logic [DATA_WIDTH-1:0]   c_o,
  output logic                    first_o,
  output logic                    last_o
);
  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic          valid_q, valid_d, first_q, first_d, last_q, last_d, load;
  logic [PW-1:0] prod_q, prod_d, a_ext, b_ext;
  logic [DATA_WIDTH-1:0] c_q, c_d;

  assign in_ready_o = en_i & (~valid_q | out_ready_i);
  assign load       = in_valid_i & in_ready_o;
  // Sign-extended unsigned product: the low PW bits equal the signed product.
  assign a_ext      = {{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i};
  assign b_ext      = {{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i};

  always_comb begin
    valid_d = valid_q;
    prod_d  = prod_q;
    c_d     = c_q;
    first_d = first_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      prod_d  = a_ext * b_ext;
      c_d     = c_i;
      first_d = first_i;
      last_d  = last_i;
    end else if (en_i && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      prod_q  <= '0;
      c_q     <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      prod_q  <= prod_d;
      c_q     <= c_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign out_valid_o = valid_q;
  assign prod_o      = prod_q;
  assign c_o         = c_q;
  assign first_o     = first_q;
  assign last_o      = last_q;
endmodule

// File: rtl/mac_engine.sv
// MAC engine: joins a/b/c streams into signed multiply-shift-accumulate results on stream d.
// Build option MAC_ENGINE_SATURATE_EN saturates the shifted product and the sum instead of wrapping.
module mac_engine
  import mac_package::*;
#(
  parameter int unsigned CNT_LEN    = MAC_CNT_LEN,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  ctrl_engine_t  ctrl_i,
  output flags_engine_t flags_o,
  mac_engine_if.slave   strm_io
);
  localparam int unsigned CntW = $clog2(CNT_LEN) + 1;
  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned PW   = 2 * DATA_WIDTH;

  state_engine_t          state_q, state_d;
  logic                   flush, en, run, start_fire;
  logic [MAC_SHIFT_W-1:0] shift_q;
  logic                   simple_q;
  logic [CntW-1:0]        len_q, cnt_q, cnt_d, cnt_nxt;
  logic                   need_c, in_valid, s1_in_ready, accept, last_in;
  logic                   s1_valid, s1_ready, s1_first, s1_last, s2_take;
  logic [PW-1:0]          s1_prod;
  logic signed [PW-1:0]   sh_full;
  logic [DW-1:0]          s1_c, sh, base, sum;
  logic [DW-1:0]          acc_q, acc_d, d_data_q, d_data_d;
  logic                   d_valid_q, d_valid_d;

  assign flush = rst_i | ctrl_i.clear;
  assign en    = ctrl_i.enable;

  always_ff @(posedge clk_i) begin
    if (flush) state_q <= ENG_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_fire) state_d = ENG_RUN;
  end

  always_comb begin
    run        = (state_q == ENG_RUN);
    start_fire = en & ctrl_i.start & (state_q == ENG_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      shift_q  <= '0;
      simple_q <= 1'b0;
      len_q    <= '0;
    end else if (start_fire) begin
      shift_q  <= ctrl_i.shift;
      simple_q <= ctrl_i.simple_mul;
      len_q    <= (ctrl_i.len == '0) ? CntW'(1) : CntW'(ctrl_i.len);
    end
  end

  // cnt==0 or cnt==len marks the first element of a vector.
  always_comb begin
    need_c   = simple_q | (cnt_q == len_q) | (cnt_q == '0);
    in_valid = run & strm_io.a_valid & strm_io.b_valid & (strm_io.c_valid | ~need_c);
    accept   = in_valid & s1_in_ready;
    cnt_nxt  = (cnt_q == len_q) ? CntW'(1) : cnt_q + CntW'(1);
    last_in  = simple_q | (cnt_nxt == len_q);
    cnt_d    = accept ? cnt_nxt : cnt_q;
  end

  assign strm_io.a_ready = accept;
  assign strm_io.b_ready = accept;
  assign strm_io.c_ready = accept & need_c;
  assign flags_o.cnt     = MAC_CNT_W'(cnt_q);

  mac_engine_mul_stage #(
    .DATA_WIDTH (DW)
  ) u_mul_stage (
    .clk_i       (clk_i),
    .rst_i       (flush),
    .en_i        (en),
    .in_valid_i  (in_valid),
    .in_ready_o  (s1_in_ready),
    .a_i         (strm_io.a_data),
    .b_i         (strm_io.b_data),
    .c_i         (strm_io.c_data),
    .first_i     (need_c),
    .last_i      (last_in),
    .out_valid_o (s1_valid),
    .out_ready_i (s1_ready),
    .prod_o      (s1_prod),
    .c_o         (s1_c),
    .first_o     (s1_first),
    .last_o      (s1_last)
  );

  // Only a last element has to wait for an undelivered d.
  assign s1_ready = en & (~s1_last | ~d_valid_q | strm_io.d_ready);
  assign s2_take  = s1_valid & s1_ready;
  assign sh_full  = $signed(s1_prod) >>> shift_q;
  assign base     = s1_first ? s1_c : acc_q;

`ifdef MAC_ENGINE_SATURATE_EN
  localparam logic [DW-1:0] SatMax = {1'b0, {(DW - 1){1'b1}}};
  localparam logic [DW-1:0] SatMin = {1'b1, {(DW - 1){1'b0}}};
  logic [DW:0] sh_hi, sum_w;

  always_comb begin
    sh_hi = sh_full[PW-1:DW-1];
    if (&sh_hi || ~|sh_hi) sh = sh_full[DW-1:0];
    else                   sh = sh_full[PW-1] ? SatMin : SatMax;
    sum_w = {base[DW-1], base} + {sh[DW-1], sh};
    if (sum_w[DW] != sum_w[DW-1]) sum = sum_w[DW] ? SatMin : SatMax;
    else                          sum = sum_w[DW-1:0];
  end
`else
  always_comb begin
    sh  = DW'(sh_full);
    sum = base + sh;
  end
`endif

  always_comb begin
    acc_d     = s2_take ? sum : acc_q;
    d_valid_d = d_valid_q;
    d_data_d  = d_data_q;
    if (en && d_valid_q && strm_io.d_ready) d_valid_d = 1'b0;
    if (s2_take && s1_last) begin
      d_valid_d = 1'b1;
      d_data_d  = sum;
    end
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      d_valid_q <= 1'b0;
      d_data_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      d_valid_q <= d_valid_d;
      d_data_q  <= d_data_d;
    end
  end

  assign strm_io.d_valid = d_valid_q;
  assign strm_io.d_data  = d_data_q;
endmodule

// File: tb/tb_mac_engine.sv
// Bench for mac_engine: directed scenarios and randomized vectors checked against an
// element-level multiply-shift-accumulate model.
module tb_mac_engine;
  import mac_package::*;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  ctrl_engine_t  ctrl;
  flags_engine_t flags;

  mac_engine_if #(.DATA_WIDTH(DW)) bus ();

  mac_engine #(
    .CNT_LEN    (MAC_CNT_LEN),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .ctrl_i  (ctrl),
    .flags_o (flags),
    .strm_io (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int dv_rise_cyc = 0;
  int c_hs = 0;
  logic dv_prev = 1'b0;
  logic [DW-1:0] got_q[$];
  int exp_q[$];
  int va[64];
  int vb[64];
  int vc[64];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (!rst && !ctrl.clear) begin
      if (bus.a_valid && bus.a_ready) last_acc_cyc <= cyc;
      if (bus.c_valid && bus.c_ready) c_hs <= c_hs + 1;
      if (bus.d_valid && !dv_prev) dv_rise_cyc <= cyc;
      if (bus.d_valid && bus.d_ready && ctrl.enable) got_q.push_back(bus.d_data);
    end
    dv_prev <= bus.d_valid;
  end

  function automatic int mac_step(input int base, input int a, input int b, input int shift);
    longint p, sh;
    p  = longint'(a) * longint'(b);
    sh = p >>> shift;
`ifdef MAC_ENGINE_SATURATE_EN
    begin
      longint s, smax, smin;
      smax = 64'sd2147483647;
      smin = -smax - 64'sd1;
      if (sh > smax) sh = smax;
      else if (sh < smin) sh = smin;
      s = longint'(base) + sh;
      if (s > smax) s = smax;
      else if (s < smin) s = smin;
      return int'(s);
    end
`else
    return base + int'(sh);
`endif
  endfunction

  task automatic build_expected(input int n, input int len, input bit simple, input int shift);
    int leff, acc, ci, pos, base;
    leff = (len == 0) ? 1 : len;
    acc  = 0;
    ci   = 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      pos = i % leff;
      if (simple || pos == 0) begin
        base = vc[ci];
        ci++;
      end else begin
        base = acc;
      end
      acc = mac_step(base, va[i], vb[i], shift);
      if (simple || pos == leff - 1) exp_q.push_back(acc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.c_valid = 1'b0;
    bus.d_ready = 1'b1;
    ctrl.start  = 1'b0;
    ctrl.enable = 1'b1;
  endtask

  task automatic do_clear();
    ctrl.clear = 1'b1;
    tick();
    ctrl.clear = 1'b0;
  endtask

  task automatic do_start(input int len, input bit simple, input int shift);
    ctrl.enable     = 1'b1;
    ctrl.start      = 1'b1;
    ctrl.len        = MAC_CNT_W'(len);
    ctrl.simple_mul = simple;
    ctrl.shift      = MAC_SHIFT_W'(shift);
    tick();
    ctrl.start = 1'b0;
  endtask

  // Streams n elements and nc c values; rmode 0: d_ready=1, 1: random, 2: 5-cycle stall.
  task automatic run_vec(input string name, input int n, input int len, input bit simple,
                         input int shift, input int nc, input bit rnd, input int rmode,
                         input bit clr, output int cycles);
    int ai, ci, cyc_n, stall;
    logic [DW-1:0] held;
    ai = 0; ci = 0; cyc_n = 0; stall = 0; held = '0;
    if (clr) do_clear();
    got_q.delete();
    build_expected(n, len, simple, shift);
    do_start(len, simple, shift);
    while ((ai < n || got_q.size() < exp_q.size()) && cyc_n < 2000) begin
      bus.a_valid = (ai < n) && (!rnd || $urandom_range(3) != 0);
      bus.b_valid = bus.a_valid;
      bus.a_data  = va[ai];
      bus.b_data  = vb[ai];
      bus.c_valid = (ci < nc) && (!rnd || $urandom_range(3) != 0);
      bus.c_data  = vc[ci];
      ctrl.enable = !rnd || ($urandom_range(7) != 0);
      if (rmode == 0)      bus.d_ready = 1'b1;
      else if (rmode == 1) bus.d_ready = 1'($urandom_range(1));
      else                 bus.d_ready = (stall >= 5);
      if (rnd) begin
        ctrl.start      = 1'($urandom_range(1));
        ctrl.len        = MAC_CNT_W'($urandom);
        ctrl.shift      = MAC_SHIFT_W'($urandom);
        ctrl.simple_mul = 1'($urandom_range(1));
      end
      @(negedge clk);
      if (bus.a_valid && bus.a_ready) ai++;
      if (bus.c_valid && bus.c_ready) ci++;
      if (rmode == 2 && stall > 0 && stall < 5) begin
        checks++;
        if (bus.d_valid !== 1'b1 || bus.d_data !== held) begin
          failures++;
          $display("FAIL %s d_hold: valid=%b data=%h required valid=1 data=%h",
                   name, bus.d_valid, bus.d_data, held);
        end
        stall++;
        if (stall == 5) begin
          checks++;
          if (bus.a_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s a_ready_stall: got %b required 0", name, bus.a_ready);
          end
        end
      end else if (rmode == 2 && stall == 0 && bus.d_valid) begin
        held  = bus.d_data;
        stall = 1;
      end
      tick();
      cyc_n++;
    end
    quiet_inputs();
    repeat (4) tick();
    cycles = cyc_n;
    checks++;
    if (cyc_n >= 2000 || ai != n) begin
      failures++;
      $display("FAIL %s timeout: accepted %0d of %0d in %0d cycles", name, ai, n, cyc_n);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s d_count: got %0d required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s d[%0d]: got %h required %h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.c_valid = 1'b1;
    ctrl.enable = 1'b1; ctrl.start = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks += 5;
    if (bus.a_ready !== 1'b0) begin failures++; $display("FAIL rst_a_ready: got %b required 0", bus.a_ready); end
    if (bus.c_ready !== 1'b0) begin failures++; $display("FAIL rst_c_ready: got %b required 0", bus.c_ready); end
    if (bus.d_valid !== 1'b0) begin failures++; $display("FAIL rst_d_valid: got %b required 0", bus.d_valid); end
    if (bus.d_data !== '0) begin failures++; $display("FAIL rst_d_data: got %h required 0", bus.d_data); end
    if (flags.cnt !== '0) begin failures++; $display("FAIL rst_cnt: got %0d required 0", flags.cnt); end
    tick();
    rst = 1'b0;
    ctrl.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.a_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_a_ready: got %b required 0", bus.a_ready);
    end
    tick();
    quiet_inputs();
  endtask

  task automatic test_accumulate();
    int cy;
    for (int i = 0; i < 4; i++) begin va[i] = i + 1; vb[i] = 1; end
    vc[0] = 10;
    run_vec("accum", 4, 4, 1'b0, 0, 1, 1'b0, 0, 1'b1, cy);
    checks += 3;
    if (got_q.size() < 1 || got_q[0] !== 32'd20) begin
      failures++;
      $display("FAIL accum_d: got %h required 00000014", (got_q.size() > 0) ? got_q[0] : '0);
    end
    if (dv_rise_cyc - last_acc_cyc != 2) begin
      failures++;
      $display("FAIL accum_latency: got %0d required 2", dv_rise_cyc - last_acc_cyc);
    end
    if (flags.cnt !== MAC_CNT_W'(4)) begin
      failures++;
      $display("FAIL accum_cnt: got %0d required 4", flags.cnt);
    end
  endtask

  task automatic test_simple_mul();
    int cy, c_before;
    va[0] = 8; va[1] = -8; vb[0] = 3; vb[1] = 3; vc[0] = 1; vc[1] = 1;
    c_before = c_hs;
    run_vec("simple", 2, 3, 1'b1, 2, 2, 1'b0, 0, 1'b1, cy);
    checks += 2;
    if (got_q.size() != 2 || got_q[0] !== 32'd7 || got_q[1] !== 32'hFFFF_FFFB) begin
      failures++;
      $display("FAIL simple_d: got %0d results, required 7 and -5", got_q.size());
    end
    if (c_hs - c_before != 2) begin
      failures++;
      $display("FAIL simple_c_ready: got %0d c handshakes required 2", c_hs - c_before);
    end
  endtask

  task automatic test_backpressure();
    int cy;
    for (int i = 0; i < 6; i++) begin va[i] = $urandom; vb[i] = $urandom; vc[i] = $urandom; end
    run_vec("stall", 6, 2, 1'b0, 3, 3, 1'b0, 2, 1'b1, cy);
  endtask

  task automatic test_clear();
    int hs, guard, cy;
    hs = 0; guard = 0;
    do_clear();
    do_start(4, 1'b0, 0);
    bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.c_valid = 1'b1;
    bus.a_data = 5; bus.b_data = 7; bus.c_data = 100;
    while (hs < 2 && guard < 20) begin
      @(negedge clk);
      if (bus.a_valid && bus.a_ready) hs++;
      tick();
      guard++;
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.c_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (flags.cnt !== MAC_CNT_W'(2)) begin
      failures++;
      $display("FAIL clr_pre_cnt: got %0d required 2", flags.cnt);
    end
    tick();
    bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.c_valid = 1'b1;
    do_clear();
    @(negedge clk);
    checks += 4;
    if (flags.cnt !== '0) begin failures++; $display("FAIL clr_cnt: got %0d required 0", flags.cnt); end
    if (bus.d_valid !== 1'b0) begin failures++; $display("FAIL clr_d_valid: got %b required 0", bus.d_valid); end
    if (bus.d_data !== '0) begin failures++; $display("FAIL clr_d_data: got %h required 0", bus.d_data); end
    if (bus.a_ready !== 1'b0) begin failures++; $display("FAIL clr_idle: got %b required 0", bus.a_ready); end
    tick();
    quiet_inputs();
    for (int i = 0; i < 3; i++) begin va[i] = $urandom; vb[i] = $urandom; vc[i] = $urandom; end
    run_vec("restart", 3, 3, 1'b0, 0, 1, 1'b0, 0, 1'b0, cy);
  endtask

  task automatic test_len_zero();
    int cy;
    for (int i = 0; i < 5; i++) begin
      va[i] = $urandom_range(2000) - 1000; vb[i] = $urandom_range(2000) - 1000; vc[i] = $urandom;
    end
    run_vec("len0", 5, 0, 1'b0, 0, 5, 1'b1, 1, 1'b1, cy);
  endtask

  task automatic test_saturate();
    int cy;
    logic [DW-1:0] want;
`ifdef MAC_ENGINE_SATURATE_EN
    want = 32'h7FFF_FFFF;
`else
    want = 32'h8000_00F0;
`endif
    va[0] = 32'h100; vb[0] = 1; vc[0] = 32'h7FFF_FFF0;
    run_vec("sat", 1, 1, 1'b0, 0, 1, 1'b0, 0, 1'b1, cy);
    checks++;
    if (got_q.size() < 1 || got_q[0] !== want) begin
      failures++;
      $display("FAIL sat_d: got %h required %h", (got_q.size() > 0) ? got_q[0] : '0, want);
    end
  endtask

  task automatic test_back_to_back();
    int cy;
    for (int i = 0; i < 8; i++) begin va[i] = $urandom; vb[i] = $urandom; vc[i] = $urandom; end
    run_vec("b2b", 8, 2, 1'b0, 1, 4, 1'b0, 0, 1'b1, cy);
    checks++;
    if (cy > 12) begin
      failures++;
      $display("FAIL b2b_throughput: got %0d cycles required at most 12", cy);
    end
  endtask

  task automatic test_random();
    int len, sft, k, n, nc, cy;
    bit s;
    for (int v = 0; v < 8; v++) begin
      len = $urandom_range(5, 1);
      s   = 1'($urandom_range(1));
      sft = $urandom_range(40);
      k   = $urandom_range(3, 1);
      n   = s ? 2 * k : len * k;
      nc  = s ? n : k;
      for (int i = 0; i < n; i++) begin va[i] = $urandom; vb[i] = $urandom; vc[i] = $urandom; end
      run_vec("random", n, len, s, sft, nc, 1'b1, 1, 1'b1, cy);
    end
  endtask

  initial begin
    ctrl = '0;
    bus.a_data = '0; bus.b_data = '0; bus.c_data = '0;
    quiet_inputs();
    test_reset();
    test_accumulate();
    test_simple_mul();
    test_backpressure();
    test_clear();
    test_len_zero();
    test_saturate();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
